// File: rtl/bgr_startup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bgr_startup_ctrl
//  Brief    : Startup kick, settle, qualification and brown-out supervision
//             sequencer for the bandgap reference core.
//  Revision : 1.0 - initial release
// ============================================================================
module bgr_startup_ctrl #(
   parameter int PORST_CYCLES  = 64,
   parameter int SETTLE_CYCLES = 1024,
   parameter int GOOD_CYCLES   = 16,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       vbg_ok,
   output logic       porst,
   output logic       bgr_ready,
   output logic       bgr_fault,
   output logic [3:0] retry_cnt,
   output logic [2:0] state_o
);

   localparam int QCNT_W = $clog2(GOOD_CYCLES + 1);

   localparam logic [CNT_W-1:0]  c_porst_last  = CNT_W'(PORST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [QCNT_W-1:0] c_good        = QCNT_W'(GOOD_CYCLES);
   localparam logic [QCNT_W-1:0] c_good_last   = QCNT_W'(GOOD_CYCLES - 1);
   localparam logic [3:0]        c_max_retries = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KICK   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_READY  = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_fail;
   logic                w_entry;
   logic                r_sync1;
   logic                r_ok_s;
   logic [CNT_W-1:0]    r_timer;
   logic [QCNT_W-1:0]   r_qcnt;

   assign state_o = r_state;
   assign w_entry = (w_next != r_state);

   // Two-flop synchronizer for the asynchronous window comparator output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_ok_s  <= 1'b0;
      end else begin
         r_sync1 <= vbg_ok;
         r_ok_s  <= r_sync1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; enable=0 overrides every other transition
   always_comb begin
      w_next = r_state;
      w_fail = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_next = ST_KICK;
         end
         ST_KICK: begin
            if (r_timer == c_porst_last) w_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_timer == c_settle_last) w_next = ST_CHECK;
         end
         ST_CHECK: begin
            // Qualification takes priority over a coincident timeout
            if (r_ok_s && (r_qcnt == c_good_last)) begin
               w_next = ST_READY;
            end else if (r_timer == c_settle_last) begin
               w_fail = 1'b1;
            end
         end
         ST_READY: begin
            if (!r_ok_s && (r_qcnt == c_good_last)) w_fail = 1'b1;
         end
         ST_FAULT: begin
            w_next = ST_FAULT;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (w_fail) begin
         w_next = (retry_cnt < c_max_retries) ? ST_KICK : ST_FAULT;
      end
      if (!enable) begin
         w_fail = 1'b0;
         w_next = ST_IDLE;
      end
   end

   // Phase timer: zero on every state entry, counts in timed states
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (w_entry) begin
         r_timer <= '0;
      end else if ((r_state == ST_KICK) || (r_state == ST_SETTLE) || (r_state == ST_CHECK)) begin
         r_timer <= r_timer + 1'b1;
      end else begin
         r_timer <= '0;
      end
   end

   // Qualify counter: consecutive good samples in CHECK, bad samples in READY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_qcnt <= '0;
      end else if (w_entry) begin
         r_qcnt <= '0;
      end else if (((r_state == ST_CHECK) && r_ok_s) || ((r_state == ST_READY) && !r_ok_s)) begin
         if (r_qcnt != c_good) r_qcnt <= r_qcnt + 1'b1;
      end else begin
         r_qcnt <= '0;
      end
   end

   // Retry counter: bumps per re-kick, cleared on READY entry and in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_cnt <= 4'd0;
      end else if (w_next == ST_IDLE) begin
         retry_cnt <= 4'd0;
      end else if (w_fail && (w_next == ST_KICK)) begin
         retry_cnt <= retry_cnt + 4'd1;
      end else if ((w_next == ST_READY) && (r_state != ST_READY)) begin
         retry_cnt <= 4'd0;
      end
   end

   // Registered outputs decoded from the next state so they track r_state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         porst     <= 1'b0;
         bgr_ready <= 1'b0;
         bgr_fault <= 1'b0;
      end else begin
         porst     <= (w_next == ST_KICK);
         bgr_ready <= (w_next == ST_READY);
         bgr_fault <= (w_next == ST_FAULT);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bgr_startup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bgr_startup_ctrl
//  Brief    : Directed self-checking bench for bgr_startup_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bgr_startup_ctrl;

   localparam int ST_IDLE   = 0;
   localparam int ST_KICK   = 1;
   localparam int ST_SETTLE = 2;
   localparam int ST_CHECK  = 3;
   localparam int ST_READY  = 4;
   localparam int ST_FAULT  = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       vbg_ok;
   logic       porst;
   logic       bgr_ready;
   logic       bgr_fault;
   logic [3:0] retry_cnt;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   logic prev_porst = 1'b0;

   bgr_startup_ctrl #(
      .PORST_CYCLES (4),
      .SETTLE_CYCLES(8),
      .GOOD_CYCLES  (3),
      .MAX_RETRIES  (2),
      .CNT_W        (12)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .vbg_ok   (vbg_ok),
      .porst    (porst),
      .bgr_ready(bgr_ready),
      .bgr_fault(bgr_fault),
      .retry_cnt(retry_cnt),
      .state_o  (state_o)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   function automatic logic [9:0] ex(input int st, input bit p, input bit r, input bit f, input int rc);
      return {3'(st), p, r, f, 4'(rc)};
   endfunction

   // Advance one clock and sample 1 ns after the edge; count porst pulses
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (porst && !prev_porst) pulse_cnt++;
         prev_porst = porst;
      end
   endtask

   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {state_o, porst, bgr_ready, bgr_fault, retry_cnt};
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed {st,porst,rdy,flt,rc}=%b required=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   // From the first KICK cycle of a kick with vbg_ok good: 4 KICK, 8 SETTLE, 3 CHECK, READY
   task automatic bringup(input string tag, input int rk);
      tick(3);
      chk({tag, "_kick_last"}, ex(ST_KICK, 1, 0, 0, rk));
      tick(1);
      chk({tag, "_settle"}, ex(ST_SETTLE, 0, 0, 0, rk));
      tick(8);
      chk({tag, "_check"}, ex(ST_CHECK, 0, 0, 0, rk));
      tick(2);
      chk({tag, "_check_last"}, ex(ST_CHECK, 0, 0, 0, rk));
      tick(1);
      chk({tag, "_ready"}, ex(ST_READY, 0, 1, 0, 0));
   endtask

   initial begin
      int width;
      rst_n  = 1'b0;
      enable = 1'b0;
      vbg_ok = 1'b1;
      tick(2);
      chk("reset", ex(ST_IDLE, 0, 0, 0, 0));
      rst_n = 1'b1;
      tick(3);
      chk("idle_disabled", ex(ST_IDLE, 0, 0, 0, 0));

      // 1. Clean bring-up
      enable = 1'b1;
      tick(1);
      chk("t1_kick_first", ex(ST_KICK, 1, 0, 0, 0));
      bringup("t1", 0);

      // 4. Glitch rejection: 2-cycle low keeps READY
      vbg_ok = 1'b0;
      tick(2);
      vbg_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t4_glitch_hold", ex(ST_READY, 0, 1, 0, 0));
      end
      // 3-cycle low drops READY and re-kicks
      vbg_ok = 1'b0;
      tick(3);
      vbg_ok = 1'b1;
      tick(1);
      chk("t4_dropout_pending", ex(ST_READY, 0, 1, 0, 0));
      tick(1);
      chk("t4_rekick", ex(ST_KICK, 1, 0, 0, 1));
      bringup("t4", 1);

      // 2. Kick retry after a CHECK timeout
      enable = 1'b0;
      vbg_ok = 1'b0;
      tick(1);
      chk("t2_disable", ex(ST_IDLE, 0, 0, 0, 0));
      tick(3);
      enable = 1'b1;
      tick(1);
      chk("t2_kick1", ex(ST_KICK, 1, 0, 0, 0));
      tick(19);
      chk("t2_check_last", ex(ST_CHECK, 0, 0, 0, 0));
      tick(1);
      chk("t2_kick2", ex(ST_KICK, 1, 0, 0, 1));
      vbg_ok = 1'b1;
      bringup("t2", 1);

      // 3. Fault after exhausting retries
      enable = 1'b0;
      vbg_ok = 1'b0;
      tick(3);
      pulse_cnt = 0;
      enable = 1'b1;
      tick(1);
      chk("t3_kick1", ex(ST_KICK, 1, 0, 0, 0));
      tick(20);
      chk("t3_kick2", ex(ST_KICK, 1, 0, 0, 1));
      tick(20);
      chk("t3_kick3", ex(ST_KICK, 1, 0, 0, 2));
      tick(20);
      chk("t3_fault", ex(ST_FAULT, 0, 0, 1, 2));
      tick(10);
      chk("t3_fault_sticky", ex(ST_FAULT, 0, 0, 1, 2));
      chk_int("t3_pulse_count", pulse_cnt, 3);
      enable = 1'b0;
      tick(1);
      chk("t3_clear", ex(ST_IDLE, 0, 0, 0, 0));

      // 5. Abort during porst, then full pulse on re-enable
      vbg_ok = 1'b1;
      tick(2);
      enable = 1'b1;
      tick(1);
      chk("t5_kick1", ex(ST_KICK, 1, 0, 0, 0));
      tick(1);
      chk("t5_kick2", ex(ST_KICK, 1, 0, 0, 0));
      enable = 1'b0;
      tick(1);
      chk("t5_abort", ex(ST_IDLE, 0, 0, 0, 0));
      enable = 1'b1;
      tick(1);
      width = 0;
      while (porst && width < 20) begin
         width++;
         tick(1);
      end
      chk_int("t5_pulse_width", width, 4);
      chk("t5_after_pulse", ex(ST_SETTLE, 0, 0, 0, 0));

      // 6. Async reset mid-SETTLE, no clock edge
      tick(2);
      chk("t6_settle", ex(ST_SETTLE, 0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_reset", ex(ST_IDLE, 0, 0, 0, 0));
      tick(2);
      chk("t6_held_reset", ex(ST_IDLE, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
